// File: rtl/mic4_pulse_seq_pkg.sv
// Shared types for the Mic4 multi-channel pulse sequencer: FSM states,
// per-channel configuration record and a few sizing helpers.
package mic4_seq_pkg;

  localparam int SEQ_N_CH      = 4;
  localparam int SEQ_CNT_WIDTH = 16;
  localparam int SEQ_REP_WIDTH = 8;

  typedef logic [SEQ_CNT_WIDTH-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // Channel timing is held at the package width; the top casts its
  // CNT_WIDTH-wide values into this record, so CNT_WIDTH must not exceed it.
  typedef struct packed {
    cnt_t delay;
    cnt_t width;
    logic pol;
  } chan_cfg_t;

  function automatic int ch_idx_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/mic4_pulse_seq_if.sv
// Register-side and pad-side signal bundle of the pulse sequencer.
interface mic4_pulse_seq_if #(
  parameter int N_CH      = mic4_seq_pkg::SEQ_N_CH,
  parameter int CNT_WIDTH = mic4_seq_pkg::SEQ_CNT_WIDTH,
  parameter int REP_WIDTH = mic4_seq_pkg::SEQ_REP_WIDTH
);

  localparam int CH_W = mic4_seq_pkg::ch_idx_width(N_CH);

  logic                 cfg_we;
  logic [CH_W-1:0]      cfg_ch;
  logic [CNT_WIDTH-1:0] cfg_delay;
  logic [CNT_WIDTH-1:0] cfg_width;
  logic                 cfg_pol;
  logic [CNT_WIDTH-1:0] period;
  logic [REP_WIDTH-1:0] rep_count;
  logic                 trig;
  logic                 abort;
  logic [N_CH-1:0]      pulse_out;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output cfg_we, cfg_ch, cfg_delay, cfg_width, cfg_pol,
    output period, rep_count, trig, abort,
    input  pulse_out, busy, done, err
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_delay, cfg_width, cfg_pol,
    input  period, rep_count, trig, abort,
    output pulse_out, busy, done, err
  );

endinterface

// File: rtl/mic4_seq_chan.sv
// One sequencer channel: staging and shadow configuration plus the
// registered window compare that drives a single pad.
module mic4_seq_chan
  import mic4_seq_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_we,
  input  chan_cfg_t i_cfg,
  input  logic      i_load,
  input  logic      i_run,
  input  logic      i_use_stage,
  input  cnt_t      i_cnt,
  output logic      o_pulse
);

  chan_cfg_t              r_stage;
  chan_cfg_t              r_shadow;
  logic                   r_pulse;
  logic [SEQ_CNT_WIDTH:0] w_end;
  logic                   w_active;

  // One extra bit on the window end so delay + width never wraps; the frame
  // counter never reaches period, which clips the window at the frame end.
  assign w_end    = {1'b0, r_shadow.delay} + {1'b0, r_shadow.width};
  assign w_active = (r_shadow.width != '0)
                 && (i_cnt >= r_shadow.delay)
                 && ({1'b0, i_cnt} < w_end);

  // NOTE: state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of block or statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage  <= '0;
      r_shadow <= '0;
      r_pulse  <= 1'b0;
    end else begin
      if (i_we) begin
        r_stage <= i_cfg;
      end
      if (i_load) begin
        r_shadow <= r_stage;
      end
      if (i_run) begin
        r_pulse <= w_active ^ r_shadow.pol;
      end else if (i_use_stage) begin
        r_pulse <= r_stage.pol;
      end else begin
        r_pulse <= r_shadow.pol;
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/mic4_pulse_seq.sv
// Multi-channel pulse sequencer: frame counter, repeat counter and run FSM
// shared by N_CH independently programmed output channels.
module mic4_pulse_seq
  import mic4_seq_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int CNT_WIDTH = 16,
  parameter int REP_WIDTH = 8
) (
  input  logic            clk_in,
  input  logic            rst_n,
  mic4_pulse_seq_if.slave bus
);

  localparam int CH_W = ch_idx_width(N_CH);

  seq_state_e           r_state;
  seq_state_e           w_next;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_period;
  logic [REP_WIDTH-1:0] r_rep_left;
  logic                 r_cont;
  logic                 r_err;

  logic                 w_load;
  logic                 w_wrap;
  logic                 w_kill;
  logic                 w_err_set;
  logic                 w_last;
  logic                 w_run;
  logic                 w_use_stage;
  chan_cfg_t            w_cfg;
  logic [N_CH-1:0]      w_pulse;

  assign w_last = (r_cnt == r_period - CNT_WIDTH'(1));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_wrap    = 1'b0;
    w_kill    = 1'b0;
    w_err_set = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.trig && !bus.abort) begin
          if (bus.period != '0) begin
            w_next = RUN;
            w_load = 1'b1;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          w_next = IDLE;
          w_kill = 1'b1;
        end else if (w_last) begin
          w_wrap = 1'b1;
          if (!r_cont && (r_rep_left == REP_WIDTH'(1))) begin
            w_next = DONE;
          end
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Frame and repeat counters; period and repeat count are captured at the trigger.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_period   <= '0;
      r_rep_left <= '0;
      r_cont     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_err_set;
      if (w_load) begin
        r_cnt      <= '0;
        r_period   <= bus.period;
        r_rep_left <= bus.rep_count;
        r_cont     <= (bus.rep_count == '0);
      end else if (w_kill) begin
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        if (w_wrap) begin
          r_cnt <= '0;
          if (!r_cont) begin
            r_rep_left <= r_rep_left - REP_WIDTH'(1);
          end
        end else begin
          r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

  // An abort forces the idle (staging) polarity on the same edge the FSM leaves RUN.
  assign w_run       = (r_state == RUN) && !bus.abort;
  assign w_use_stage = (r_state == IDLE) || w_kill;

  assign w_cfg.delay = cnt_t'(bus.cfg_delay);
  assign w_cfg.width = cnt_t'(bus.cfg_width);
  assign w_cfg.pol   = bus.cfg_pol;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic w_we;

    // Indices at or beyond N_CH match no channel, so such writes are dropped.
    assign w_we = bus.cfg_we && (bus.cfg_ch == CH_W'(gi));

    mic4_seq_chan u_chan (
      .clk         (clk_in),
      .rst_n       (rst_n),
      .i_we        (w_we),
      .i_cfg       (w_cfg),
      .i_load      (w_load),
      .i_run       (w_run),
      .i_use_stage (w_use_stage),
      .i_cnt       (cnt_t'(r_cnt)),
      .o_pulse     (w_pulse[gi])
    );
  end

  assign bus.pulse_out = w_pulse;
  assign bus.busy      = (r_state == RUN);
  assign bus.done      = (r_state == DONE);
  assign bus.err       = r_err;

endmodule

// File: tb/tb_mic4_pulse_seq.sv
// Directed bench for mic4_pulse_seq: per-cycle output traces are captured
// into bit masks (bit k = cycle T+k after the trigger edge T) and compared.
module tb_mic4_pulse_seq;

  localparam int N_CH      = 4;
  localparam int CNT_WIDTH = 16;
  localparam int REP_WIDTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] ch_log [N_CH];
  logic [63:0] busy_log;
  logic [63:0] done_log;
  logic [63:0] err_log;

  mic4_pulse_seq_if #(.N_CH(N_CH), .CNT_WIDTH(CNT_WIDTH), .REP_WIDTH(REP_WIDTH)) bus ();

  mic4_pulse_seq #(.N_CH(N_CH), .CNT_WIDTH(CNT_WIDTH), .REP_WIDTH(REP_WIDTH)) dut (
    .clk_in (clk),
    .rst_n  (rst_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] span(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [15:0] d,
                           input logic [15:0] w, input logic p);
    bus.cfg_we    = 1'b1;
    bus.cfg_ch    = ch;
    bus.cfg_delay = d;
    bus.cfg_width = w;
    bus.cfg_pol   = p;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic start(input logic [15:0] per, input logic [7:0] rep);
    bus.period    = per;
    bus.rep_count = rep;
    bus.trig      = 1'b1;
    tick();
    bus.trig = 1'b0;
  endtask

  // Samples cycles T+1..T+n; optional abort, retrigger or ch0 width rewrite
  // is driven during cycle T+k so the DUT samples it at edge T+k.
  task automatic capture(input int n, input int abort_k, input int retrig_k,
                         input int wr_k, input logic [15:0] wr_width);
    for (int c = 0; c < N_CH; c++) ch_log[c] = '0;
    busy_log = '0;
    done_log = '0;
    err_log  = '0;
    for (int k = 1; k <= n; k++) begin
      for (int c = 0; c < N_CH; c++) ch_log[c][k] = bus.pulse_out[c];
      busy_log[k] = bus.busy;
      done_log[k] = bus.done;
      err_log[k]  = bus.err;
      if (k == abort_k)  bus.abort = 1'b1;
      if (k == retrig_k) bus.trig  = 1'b1;
      if (k == wr_k) begin
        bus.cfg_we    = 1'b1;
        bus.cfg_ch    = 2'd0;
        bus.cfg_delay = 16'd3;
        bus.cfg_width = wr_width;
        bus.cfg_pol   = 1'b0;
      end
      tick();
      bus.abort  = 1'b0;
      bus.trig   = 1'b0;
      bus.cfg_we = 1'b0;
    end
  endtask

  initial begin
    bus.cfg_we    = 1'b0;
    bus.cfg_ch    = '0;
    bus.cfg_delay = '0;
    bus.cfg_width = '0;
    bus.cfg_pol   = 1'b0;
    bus.period    = '0;
    bus.rep_count = '0;
    bus.trig      = 1'b0;
    bus.abort     = 1'b0;

    #3;
    check("rst_pulse", 64'(bus.pulse_out), 64'd0);
    check("rst_busy",  64'(bus.busy), 64'd0);
    check("rst_done",  64'(bus.done), 64'd0);
    check("rst_err",   64'(bus.err),  64'd0);
    #9 rst_n = 1'b1;
    tick();
    tick();
    check("idle_pulse", 64'(bus.pulse_out), 64'd0);

    // Single shot: delay 3, width 5, period 20, one frame.
    cfg_write(2'd0, 16'd3, 16'd5, 1'b0);
    start(16'd20, 8'd1);
    capture(24, 0, 0, 0, 16'd0);
    check("single_ch0",   ch_log[0], span(5, 9));
    check("single_other", ch_log[1] | ch_log[2] | ch_log[3], 64'd0);
    check("single_busy",  busy_log, span(1, 20));
    check("single_done",  done_log, span(21, 21));
    check("single_err",   err_log, 64'd0);

    // Clipping and active-low polarity across two frames.
    cfg_write(2'd1, 16'd18, 16'd10, 1'b1);
    tick();
    check("idle_stage_pol", 64'(bus.pulse_out[1]), 64'd1);
    start(16'd20, 8'd2);
    capture(44, 0, 0, 0, 16'd0);
    check("clip_ch1",  ch_log[1], span(1, 44) & ~(span(20, 21) | span(40, 41)));
    check("clip_ch0",  ch_log[0], span(5, 9) | span(25, 29));
    check("clip_busy", busy_log, span(1, 40));
    check("clip_done", done_log, span(41, 41));

    // Continuous frames of 8, aborted at edge T+40.
    cfg_write(2'd1, 16'd0, 16'd0, 1'b0);
    start(16'd8, 8'd0);
    capture(48, 40, 0, 0, 16'd0);
    check("cont_ch0",  ch_log[0], span(5, 9) | span(13, 17) | span(21, 25)
                                | span(29, 33) | span(37, 40));
    check("cont_ch1",  ch_log[1], 64'd0);
    check("cont_busy", busy_log, span(1, 40));
    check("cont_done", done_log, 64'd0);

    // Shadowing: width rewrite and a retrigger while running.
    start(16'd20, 8'd1);
    capture(24, 0, 3, 2, 16'd2);
    check("shadow_ch0",  ch_log[0], span(5, 9));
    check("shadow_busy", busy_log, span(1, 20));
    check("shadow_done", done_log, span(21, 21));
    check("shadow_err",  err_log, 64'd0);

    // Next run picks up width 2; delay == period and width 0 never fire.
    cfg_write(2'd2, 16'd20, 16'd4, 1'b0);
    cfg_write(2'd3, 16'd19, 16'd4, 1'b0);
    start(16'd20, 8'd1);
    capture(24, 0, 0, 0, 16'd0);
    check("next_ch0",   ch_log[0], span(5, 6));
    check("width0_ch1", ch_log[1], 64'd0);
    check("dlyper_ch2", ch_log[2], 64'd0);
    check("lastcnt_ch3", ch_log[3], span(21, 21));
    check("next_done",  done_log, span(21, 21));

    // Rejected trigger with period 0.
    start(16'd0, 8'd1);
    capture(4, 0, 0, 0, 16'd0);
    check("per0_err",  err_log, span(1, 1));
    check("per0_busy", busy_log, 64'd0);

    // Abort and trigger together in IDLE.
    bus.period = 16'd20;
    bus.trig   = 1'b1;
    bus.abort  = 1'b1;
    tick();
    bus.trig  = 1'b0;
    bus.abort = 1'b0;
    capture(4, 0, 0, 0, 16'd0);
    check("abtrig_busy", busy_log, 64'd0);
    check("abtrig_err",  err_log, 64'd0);
    check("abtrig_done", done_log, 64'd0);

    // Asynchronous reset in the middle of a frame.
    cfg_write(2'd0, 16'd3, 16'd5, 1'b0);
    cfg_write(2'd1, 16'd0, 16'd0, 1'b1);
    start(16'd20, 8'd1);
    capture(7, 0, 0, 0, 16'd0);
    check("prerst_pulse", 64'(bus.pulse_out), 64'h3);
    check("prerst_busy",  64'(bus.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pulse", 64'(bus.pulse_out), 64'd0);
    check("arst_busy",  64'(bus.busy), 64'd0);
    check("arst_done",  64'(bus.done), 64'd0);
    check("arst_err",   64'(bus.err),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    cfg_write(2'd0, 16'd3, 16'd5, 1'b0);
    start(16'd20, 8'd1);
    capture(24, 0, 0, 0, 16'd0);
    check("postrst_ch0",  ch_log[0], span(5, 9));
    check("postrst_ch1",  ch_log[1], 64'd0);
    check("postrst_busy", busy_log, span(1, 20));
    check("postrst_done", done_log, span(21, 21));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mic4_pulse_seq.md
# mic4_pulse_seq

Parametrised multi-channel pulse sequencer for the Mic4 test firmware. It generalises the fixed-length single-pulse stretchers to N independent channels, each with a runtime-programmable delay, width and polarity, all timed against a shared frame counter. Frames repeat for a programmable count, or continuously until aborted. It sits in the control clock domain between the register interface and the Mic4 pad drivers (A_pulse, D_pulse, GRST_N, spare strobes).

## Interface
Parameters:
- N_CH, 4, number of output channels (1..16)
- CNT_WIDTH, 16, width of frame counter, delay, width and period
- REP_WIDTH, 8, width of the repeat count

Ports:
- clk_in  in  1  control clock (100 MHz)
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- cfg_we  in  1  write strobe for per-channel staging registers
- cfg_ch  in  $clog2(N_CH) (min 1)  channel index for the write
- cfg_delay  in  CNT_WIDTH  start offset within the frame
- cfg_width  in  CNT_WIDTH  active length in cycles; 0 disables the channel
- cfg_pol  in  1  1 = active-low output
- period  in  CNT_WIDTH  frame length in cycles; sampled at trigger
- rep_count  in  REP_WIDTH  number of frames; 0 = continuous; sampled at trigger
- trig  in  1  single-cycle start request
- abort  in  1  single-cycle stop request
- pulse_out  out  N_CH  channel outputs (registered)
- busy  out  1  sequence running
- done  out  1  one-cycle pulse when the final frame completes
- err  out  1  one-cycle pulse when a trigger is rejected

## Operation
- Staging: `cfg_we` writes delay, width and pol for `cfg_ch` in any state. A write with `cfg_ch >= N_CH` is ignored.
- Shadow: on an accepted trigger, the staging registers, `period` and `rep_count` are copied into shadow registers. A running sequence uses only the shadow copies, so staging writes take effect at the next trigger.
- FSM states:
  - IDLE: `trig` with `period != 0` goes to RUN. `trig` with `period == 0` stays in IDLE and pulses `err`.
  - RUN: frame counter `cnt` counts 0..period-1, then wraps to 0.
    - At a wrap with finite repeats: decrement the remaining-frame count. If the decremented value is 0, go to DONE.
    - With `rep_count == 0`: wrap forever.
  - DONE: one cycle with `done`=1, then IDLE.
- Channel active condition: `width != 0 && cnt >= delay && cnt < delay + width`.
  - The sum is computed in CNT_WIDTH+1 bits, so there is no wrap.
  - A pulse is clipped at the frame end; it never spills into the next frame.
  - `delay >= period` means the channel is never active.
- Output: `pulse_out[i] = active_i XOR pol_i` while in RUN. In IDLE and DONE, `pulse_out[i] = pol_i`, i.e. inactive. In IDLE this uses the staging pol; otherwise the shadow pol.
- `trig` while busy is ignored; `err` is not pulsed.
- `abort` in RUN goes to IDLE next cycle, with outputs inactive and no `done`.
- `abort` and `trig` in the same IDLE cycle: abort wins and the trigger is dropped.
- Reset values: all registers 0, FSM in IDLE. Hence `pulse_out`=0, `busy`=0, `done`=0, `err`=0.

## Timing
- `trig` sampled high at edge T: RUN with `cnt`=0 in cycle T+1, and `busy`=1 from T+1.
- Channel output is high (pol 0) from cycle T+2+delay through T+1+delay+min(width, period-delay), inclusive. Latency is one cycle, because the output is registered from the compare.
- For F frames: the last `cnt`=period-1 occurs in cycle T+F·period. `done`=1 and `busy`=0 occur in cycle T+F·period+1. `busy` falls in the same cycle that `done` rises.
- Outputs return inactive one cycle after the last active count (the registered view of the final count).
- `err` is asserted in cycle T+1 for a rejected trigger.
- Earliest retrigger: a trigger sampled in the cycle after `done`.
- `abort` sampled at edge A: `busy`=0 and outputs inactive from cycle A+1.

## Structure
- Package `mic4_seq_pkg` holds:
  - the FSM state enum (IDLE, RUN, DONE);
  - a channel-config struct {delay, width, pol}, parameterised by CNT_WIDTH through package localparams matching the defaults.
- Sub-module `mic4_seq_chan`: one per channel, via a generate loop. It holds the staging and shadow registers and the compare-and-output register. Its inputs are `cnt`, run and load strobes, and its config write port.
- The top level holds the FSM, frame counter, repeat counter and error/done logic.

## Test plan
- Single shot: ch0 delay=3, width=5, pol=0; period=20, rep=1; trig at T.
  - Expect `pulse_out[0]` high in T+5..T+9.
  - Expect `done` at T+21 and `busy` high T+1..T+20.
- Clipping and polarity: ch1 delay=18, width=10, pol=1; period=20, rep=2.
  - Expect ch1 low for 2 cycles per frame, at T+20..T+21 and T+40..T+41.
  - Expect ch1 high elsewhere; `done` at T+41.
- Continuous and abort: rep=0, period=8.
  - Expect pulses repeating every 8 cycles for 5 frames.
  - `abort` at A: `busy`=0 at A+1, outputs inactive, `done` never asserted.
- Shadowing: reprogram ch0 width 5→2 mid-run.
  - Current run keeps width 5.
  - Next trigger produces width 2.
  - `trig` during the run is ignored and no `err` is pulsed.
- Error and corners: `trig` with period=0 gives `err` at T+1 and `busy` stays 0. `width`=0 and `delay`=period each give a never-active channel. `abort`+`trig` together in IDLE leaves the block idle.
- Async reset: assert `rst_n`=0 mid-frame.
  - Outputs, `busy`, `done` and `err` go to 0 immediately, without waiting for a clock edge.
  - After release, a new trigger runs correctly from `cnt`=0.
